// File: rtl/lieat_exu_com_csrrf_pkg.sv
// Shared CSR definitions for the machine-mode CSR register file:
// address map, data/index widths, mstatus reset value and an implemented-index check.
package lieat_exu_com_csrrf_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned CSR_IDX = 12;

    localparam logic [XLEN-1:0] MSTATUS_RV_DEF = 32'h0000_1800;

    typedef enum logic [CSR_IDX-1:0] {
        CSR_MSTATUS_ADDR   = 12'h300,
        CSR_MTVEC_ADDR     = 12'h305,
        CSR_MSCRATCH_ADDR  = 12'h340,
        CSR_MEPC_ADDR      = 12'h341,
        CSR_MCAUSE_ADDR    = 12'h342,
        CSR_MCYCLE_ADDR    = 12'hB00,
        CSR_MINSTRET_ADDR  = 12'hB02,
        CSR_MCYCLEH_ADDR   = 12'hB80,
        CSR_MINSTRETH_ADDR = 12'hB82,
        CSR_MVENDORID_ADDR = 12'hF11,
        CSR_MARCHID_ADDR   = 12'hF12
    } csr_addr_e;

    // Counter indices stay implemented even when the counters are configured out.
    function automatic logic csr_implemented(input logic [CSR_IDX-1:0] idx);
        case (idx)
            CSR_MSTATUS_ADDR, CSR_MTVEC_ADDR, CSR_MSCRATCH_ADDR, CSR_MEPC_ADDR,
            CSR_MCAUSE_ADDR, CSR_MCYCLE_ADDR, CSR_MINSTRET_ADDR, CSR_MCYCLEH_ADDR,
            CSR_MINSTRETH_ADDR, CSR_MVENDORID_ADDR, CSR_MARCHID_ADDR: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lieat_exu_com_csrcnt.sv
// 64-bit CSR counter with per-half write enables; a write in a cycle suppresses the increment.
// ENABLE_P=0 removes all flops and ties the count to zero.
module lieat_exu_com_csrcnt #(
    parameter bit ENABLE_P = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wdata_lo_i,
    input  logic [31:0] wdata_hi_i,
    output logic [63:0] cnt_o
);

    if (ENABLE_P) begin : g_cnt
        logic [63:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (wr_lo_i || wr_hi_i) begin
                if (wr_lo_i) cnt_d[31:0]  = wdata_lo_i;
                if (wr_hi_i) cnt_d[63:32] = wdata_hi_i;
            end else if (inc_i) begin
                cnt_d = cnt_q + 64'd1;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) cnt_q <= '0;
            else        cnt_q <= cnt_d;
        end

        assign cnt_o = cnt_q;
    end else begin : g_off
        logic unused_in;
        assign unused_in = ^{clk, rst_n, inc_i, wr_lo_i, wr_hi_i, wdata_lo_i, wdata_hi_i};
        assign cnt_o     = '0;
    end

endmodule

// File: rtl/lieat_exu_com_csrrf.sv
// Machine-mode CSR register file: combinational read-before-write, two write ports
// (secondary wins on collision). Counters are built only with LIEAT_CSR_COUNTERS_EN defined.
module lieat_exu_com_csrrf
    import lieat_exu_com_csrrf_pkg::*;
#(
    parameter int unsigned       XLEN_P     = XLEN,
    parameter int unsigned       IDX_P      = CSR_IDX,
    parameter logic [XLEN_P-1:0] MSTATUS_RV = MSTATUS_RV_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              csr_ena,
    input  logic              csr_write,
    input  logic              csr_read,
    input  logic [IDX_P-1:0]  csr_idx,
    input  logic [XLEN_P-1:0] csr_wdata,
    input  logic [IDX_P-1:0]  csr_idx2,
    input  logic [XLEN_P-1:0] csr_wdata2,
    output logic [XLEN_P-1:0] csr_rdata,
    output logic              csr_illegal,
    input  logic              instret_inc,
    output logic [XLEN_P-1:0] mtvec_o,
    output logic [XLEN_P-1:0] mepc_o
);

`ifdef LIEAT_CSR_COUNTERS_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic [XLEN_P-1:0] mstatus_q, mstatus_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
    logic [XLEN_P-1:0] mepc_q, mepc_d, mcause_q, mcause_d;
    logic [XLEN_P-1:0] cyc_dlo, cyc_dhi, ins_dlo, ins_dhi;
    logic              cyc_wlo, cyc_whi, ins_wlo, ins_whi;
    logic [63:0]       mcycle, minstret;
    logic [XLEN_P-1:0] rd_val;

    logic [1:0]        we_a;
    logic [IDX_P-1:0]  idx_a [2];
    logic [XLEN_P-1:0] wd_a  [2];

    assign we_a[0]  = csr_ena && csr_write;
    assign we_a[1]  = csr_ena && (csr_idx2 != '0);
    assign idx_a[0] = csr_idx;
    assign idx_a[1] = csr_idx2;
    assign wd_a[0]  = csr_wdata;
    assign wd_a[1]  = csr_wdata2;

    // Port 1 is decoded after port 0, so the secondary write wins on an index collision.
    always_comb begin
        mstatus_d  = mstatus_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        cyc_wlo = 1'b0; cyc_whi = 1'b0; ins_wlo = 1'b0; ins_whi = 1'b0;
        cyc_dlo = '0;   cyc_dhi = '0;   ins_dlo = '0;   ins_dhi = '0;
        for (int unsigned p = 0; p < 2; p++) begin
            if (we_a[p]) begin
                case (idx_a[p])
                    CSR_MSTATUS_ADDR:   mstatus_d  = wd_a[p];
                    CSR_MTVEC_ADDR:     mtvec_d    = {wd_a[p][XLEN_P-1:2], 2'b00};
                    CSR_MSCRATCH_ADDR:  mscratch_d = wd_a[p];
                    CSR_MEPC_ADDR:      mepc_d     = {wd_a[p][XLEN_P-1:2], 2'b00};
                    CSR_MCAUSE_ADDR:    mcause_d   = wd_a[p];
                    CSR_MCYCLE_ADDR:    begin cyc_wlo = 1'b1; cyc_dlo = wd_a[p]; end
                    CSR_MCYCLEH_ADDR:   begin cyc_whi = 1'b1; cyc_dhi = wd_a[p]; end
                    CSR_MINSTRET_ADDR:  begin ins_wlo = 1'b1; ins_dlo = wd_a[p]; end
                    CSR_MINSTRETH_ADDR: begin ins_whi = 1'b1; ins_dhi = wd_a[p]; end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatus_q  <= MSTATUS_RV;
            mtvec_q    <= '0;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
        end else begin
            mstatus_q  <= mstatus_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
        end
    end

    lieat_exu_com_csrcnt #(.ENABLE_P(CNT_EN)) u_mcycle (
        .clk(clk), .rst_n(rst_n), .inc_i(1'b1),
        .wr_lo_i(cyc_wlo), .wr_hi_i(cyc_whi),
        .wdata_lo_i(cyc_dlo), .wdata_hi_i(cyc_dhi), .cnt_o(mcycle)
    );

    lieat_exu_com_csrcnt #(.ENABLE_P(CNT_EN)) u_minstret (
        .clk(clk), .rst_n(rst_n), .inc_i(instret_inc),
        .wr_lo_i(ins_wlo), .wr_hi_i(ins_whi),
        .wdata_lo_i(ins_dlo), .wdata_hi_i(ins_dhi), .cnt_o(minstret)
    );

    always_comb begin
        rd_val = '0;
        case (csr_idx)
            CSR_MSTATUS_ADDR:   rd_val = mstatus_q;
            CSR_MTVEC_ADDR:     rd_val = mtvec_q;
            CSR_MSCRATCH_ADDR:  rd_val = mscratch_q;
            CSR_MEPC_ADDR:      rd_val = mepc_q;
            CSR_MCAUSE_ADDR:    rd_val = mcause_q;
            CSR_MCYCLE_ADDR:    rd_val = mcycle[31:0];
            CSR_MCYCLEH_ADDR:   rd_val = mcycle[63:32];
            CSR_MINSTRET_ADDR:  rd_val = minstret[31:0];
            CSR_MINSTRETH_ADDR: rd_val = minstret[63:32];
            default:            rd_val = '0;
        endcase
    end

    assign csr_rdata   = (csr_ena && csr_read) ? rd_val : '0;
    assign csr_illegal = csr_ena && !csr_implemented(csr_idx);
    assign mtvec_o     = mtvec_q;
    assign mepc_o      = mepc_q;

endmodule

// File: tb/tb_lieat_exu_com_csrrf.sv
// Scoreboard bench for lieat_exu_com_csrrf; expectations follow LIEAT_CSR_COUNTERS_EN if defined.
module tb_lieat_exu_com_csrrf;

`ifdef LIEAT_CSR_COUNTERS_EN
    localparam bit CNT = 1'b1;
`else
    localparam bit CNT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        csr_ena, csr_write, csr_read, instret_inc;
    logic [11:0] csr_idx, csr_idx2;
    logic [31:0] csr_wdata, csr_wdata2, csr_rdata, mtvec_o, mepc_o;
    logic        csr_illegal;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        illegal;
        logic        chk_o;
        logic [31:0] mtvec;
        logic [31:0] mepc;
        string       name;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    lieat_exu_com_csrrf dut (
        .clk(clk), .rst_n(rst_n),
        .csr_ena(csr_ena), .csr_write(csr_write), .csr_read(csr_read),
        .csr_idx(csr_idx), .csr_wdata(csr_wdata),
        .csr_idx2(csr_idx2), .csr_wdata2(csr_wdata2),
        .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
        .instret_inc(instret_inc), .mtvec_o(mtvec_o), .mepc_o(mepc_o)
    );

    task automatic req(input logic wr, input logic rd, input logic [11:0] idx,
                       input logic [31:0] wd, input logic [11:0] idx2, input logic [31:0] wd2,
                       input logic [31:0] er, input logic ei, input string nm,
                       input logic chk = 1'b0, input logic [31:0] emtvec = '0,
                       input logic [31:0] emepc = '0);
        exp_t e;
        @(posedge clk); #1;
        csr_ena = 1'b1; csr_write = wr; csr_read = rd;
        csr_idx = idx; csr_wdata = wd; csr_idx2 = idx2; csr_wdata2 = wd2;
        instret_inc = 1'b0;
        e.rdata = er; e.illegal = ei; e.chk_o = chk; e.mtvec = emtvec; e.mepc = emepc; e.name = nm;
        sbq.push_back(e);
    endtask

    task automatic idle(input logic inc);
        @(posedge clk); #1;
        csr_ena = 1'b0; csr_write = 1'b0; csr_read = 1'b0;
        csr_idx2 = '0; instret_inc = inc;
    endtask

    always @(negedge clk) begin
        if (rst_n && csr_ena) begin
            if (sbq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_response: got rdata=%h with no expectation queued", csr_rdata);
            end else begin
                mon_e = sbq.pop_front();
                checks++;
                if (csr_rdata !== mon_e.rdata) begin
                    errors++;
                    $display("FAIL %s rdata: got %h expected %h", mon_e.name, csr_rdata, mon_e.rdata);
                end
                checks++;
                if (csr_illegal !== mon_e.illegal) begin
                    errors++;
                    $display("FAIL %s illegal: got %b expected %b", mon_e.name, csr_illegal, mon_e.illegal);
                end
                if (mon_e.chk_o) begin
                    checks += 2;
                    if (mtvec_o !== mon_e.mtvec) begin
                        errors++;
                        $display("FAIL %s mtvec_o: got %h expected %h", mon_e.name, mtvec_o, mon_e.mtvec);
                    end
                    if (mepc_o !== mon_e.mepc) begin
                        errors++;
                        $display("FAIL %s mepc_o: got %h expected %h", mon_e.name, mepc_o, mon_e.mepc);
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; csr_ena = 1'b0; csr_write = 1'b0; csr_read = 1'b0; instret_inc = 1'b0;
        csr_idx = '0; csr_idx2 = '0; csr_wdata = '0; csr_wdata2 = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        req(0, 1, 12'h300, 0, 0, 0, 32'h0000_1800, 0, "init_mstatus", 1, 0, 0);
        req(0, 1, 12'h305, 0, 0, 0, 32'h0, 0, "init_mtvec");

        req(1, 1, 12'h340, 32'hDEAD_BEEF, 0, 0, 32'h0, 0, "mscratch_rbw");
        req(0, 1, 12'h340, 0, 0, 0, 32'hDEAD_BEEF, 0, "mscratch_rd");

        req(1, 1, 12'h341, 32'h8000_0102, 12'h342, 32'h1, 32'h0, 0, "ecall_rbw", 1, 0, 0);
        req(0, 1, 12'h341, 0, 0, 0, 32'h8000_0100, 0, "ecall_mepc", 1, 0, 32'h8000_0100);
        req(0, 1, 12'h342, 0, 0, 0, 32'h1, 0, "ecall_mcause");

        req(1, 0, 12'h305, 32'h0000_1003, 0, 0, 32'h0, 0, "mtvec_wr_noread");
        req(0, 1, 12'h305, 0, 0, 0, 32'h0000_1000, 0, "mtvec_warl", 1, 32'h0000_1000, 32'h8000_0100);

        req(1, 1, 12'h340, 32'h1, 12'h340, 32'h2, 32'hDEAD_BEEF, 0, "collision_rbw");
        req(0, 1, 12'h340, 0, 12'h342, 32'h7, 32'h2, 0, "collision");
        req(0, 1, 12'h342, 0, 0, 0, 32'h7, 0, "idx2_without_write");

        req(1, 1, 12'h7C0, 32'h55, 0, 0, 32'h0, 1, "illegal");
        req(1, 1, 12'h7C0, 32'h55, 12'h340, 32'h33, 32'h0, 1, "illegal_with_idx2");
        req(0, 1, 12'h340, 0, 0, 0, 32'h33, 0, "illegal_noblock");
        req(1, 1, 12'hF11, 32'h123, 0, 0, 32'h0, 0, "mvendorid_wr");
        req(0, 1, 12'hF11, 0, 0, 0, 32'h0, 0, "mvendorid_rd");
        req(0, 1, 12'hF12, 0, 0, 0, 32'h0, 0, "marchid_rd");

        req(1, 0, 12'hB80, 32'hFFFF_FFFF, 0, 0, 32'h0, 0, "mcycleh_wr");
        req(1, 0, 12'hB00, 32'hFFFF_FFFF, 0, 0, 32'h0, 0, "mcycle_wr");
        req(0, 1, 12'hB80, 0, 0, 0, CNT ? 32'hFFFF_FFFF : 32'h0, 0, "mcycleh_max");
        req(0, 1, 12'hB80, 0, 0, 0, 32'h0, 0, "mcycleh_wrap");
        req(0, 1, 12'hB00, 0, 0, 0, CNT ? 32'h1 : 32'h0, 0, "mcycle_wrap");

        idle(1); idle(1); idle(1);
        req(0, 1, 12'hB02, 0, 0, 0, CNT ? 32'h3 : 32'h0, 0, "minstret_cnt");
        req(0, 1, 12'hB82, 0, 0, 0, 32'h0, 0, "minstreth");

        req(1, 0, 12'h300, 32'h8, 0, 0, 32'h0, 0, "mstatus_wr");
        req(1, 0, 12'hB00, 32'h10, 0, 0, 32'h0, 0, "mcycle_preset_wr");
        req(0, 1, 12'hB00, 0, 0, 0, CNT ? 32'h10 : 32'h0, 0, "mcycle_preset");
        req(0, 1, 12'h300, 0, 0, 0, 32'h8, 0, "mstatus_written");
        idle(0);
        @(negedge clk); rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        req(0, 1, 12'hB00, 0, 0, 0, CNT ? 32'h1 : 32'h0, 0, "rst_mcycle");
        req(0, 1, 12'hB80, 0, 0, 0, 32'h0, 0, "rst_mcycleh");
        req(0, 1, 12'h300, 0, 0, 0, 32'h0000_1800, 0, "rst_mstatus", 1, 0, 0);
        req(0, 1, 12'h340, 0, 0, 0, 32'h0, 0, "rst_mscratch");
        req(0, 1, 12'h341, 0, 0, 0, 32'h0, 0, "rst_mepc");
        req(0, 1, 12'h342, 0, 0, 0, 32'h0, 0, "rst_mcause");
        req(0, 1, 12'h305, 0, 0, 0, 32'h0, 0, "rst_mtvec");
        idle(0);

        for (int i = 0; i < 10 && sbq.size() != 0; i++) @(negedge clk);
        if (sbq.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain: got %0d pending expectations, expected 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
